eth_rx_frame_fifo: RTL and testbench

- Parametrised store-and-forward receive buffer, inserted between the 1G MAC RX AXI-Stream and ethernet_frame_parser in the Ethernet subsystem.
- Generalises the existing direct MAC-to-parser connection: configurable data width and depth, and real downstream backpressure in place of the tied-high ready.
- Adds frame-level commit/discard:
  - frames the MAC flags bad (tuser=1 on the tlast beat) are discarded;
  - frames that overflow the buffer are discarded;
  - saturating statistics are kept.
- Only complete good frames ever reach the parser.

---
 rtl/eth_pkg.sv | 19 +
 rtl/eth_rx_frame_fifo_if.sv | 17 +
 rtl/eth_sdp_ram.sv | 25 ++
 rtl/eth_rx_frame_fifo.sv | 168 ++++++++++++++++
 tb/tb_eth_rx_frame_fifo.sv | 377 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/eth_pkg.sv
// Shared types and helpers for the Ethernet receive path.
package eth_pkg;

  // Default stream width shared by the MAC, the RX frame FIFO and the parser.
  localparam int ETH_DATA_WIDTH = 8;

  // Input-side frame FSM of the RX frame FIFO.
  typedef enum logic [1:0] {
    SYNC,
    WRITE,
    DROP
  } rx_fifo_state_t;

  // Pointer width for a power-of-two buffer: address bits plus one wrap bit.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/eth_rx_frame_fifo_if.sv
// AXI-Stream beat bundle used on both sides of the RX frame FIFO.
interface eth_rx_frame_fifo_if
  import eth_pkg::*;
#(
  parameter int DATA_WIDTH = ETH_DATA_WIDTH
) ();

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic                  tuser;

  modport master (output tdata, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tvalid, tlast, tuser, output tready);

endinterface

// File: rtl/eth_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port (BRAM style).
module eth_sdp_ram #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 2048
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port and registered read port share the single clock.
  // NOTE: the array has no reset on purpose; a reset would stop BRAM inference,
  // and entries are only ever read after they were written and committed.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/eth_rx_frame_fifo.sv
// Store-and-forward RX frame buffer between the MAC and the frame parser.
// Frames are written speculatively and only become readable once their last
// beat arrives clean; bad and overflowing frames are rolled back and counted.
module eth_rx_frame_fifo
  import eth_pkg::*;
#(
  parameter int DATA_WIDTH = ETH_DATA_WIDTH,
  parameter int DEPTH      = 2048,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  eth_rx_frame_fifo_if.slave      s_axis,
  eth_rx_frame_fifo_if.master     m_axis,
  output logic [CNT_WIDTH-1:0]    stat_good_frames,
  output logic [CNT_WIDTH-1:0]    stat_bad_frames,
  output logic [CNT_WIDTH-1:0]    stat_ovf_frames,
  output logic [$clog2(DEPTH):0]  fifo_level
);

  localparam int ADDR = $clog2(DEPTH);
  localparam int PW   = ptr_width(DEPTH);
  localparam int EW   = DATA_WIDTH + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [EW-1:0] entry_t;

  rx_fifo_state_t state;
  ptr_t           wr_ptr;
  ptr_t           wr_commit;
  ptr_t           rd_ptr;
  ptr_t           free;
  logic           tready_q;
  logic           beat;
  logic           full;
  logic           ram_we;

  logic           rd_en;
  logic           rd_pend;
  entry_t         ram_q;
  logic           out_v;
  entry_t         out_q;
  logic           skid_v;
  entry_t         skid_q;
  logic           pop;
  logic [1:0]     held;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Space is measured against the pre-edge read pointer, so a same-cycle read
  // only ever makes the estimate conservative.
  assign free       = ptr_t'(DEPTH) - (wr_ptr - rd_ptr);
  assign full       = (free == '0);
  assign beat       = s_axis.tvalid && tready_q;
  assign ram_we     = (state == WRITE) && beat && !full && !(s_axis.tlast && s_axis.tuser);
  assign fifo_level = wr_commit - rd_ptr;

  assign s_axis.tready = tready_q;
  assign m_axis.tvalid = out_v;
  assign m_axis.tdata  = out_q[DATA_WIDTH-1:0];
  assign m_axis.tlast  = out_q[DATA_WIDTH];
  assign m_axis.tuser  = 1'b0;

  eth_sdp_ram #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr[ADDR-1:0]),
    .wdata ({s_axis.tlast, s_axis.tdata}),
    .re    (rd_en),
    .raddr (rd_ptr[ADDR-1:0]),
    .rdata (ram_q)
  );

  // Input FSM: resynchronise to a frame boundary, write/commit/roll back frames,
  // and keep the saturating statistics.
  // NOTE: all state here uses non-blocking assignments so every register sees
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= SYNC;
      wr_ptr           <= '0;
      wr_commit        <= '0;
      tready_q         <= 1'b0;
      stat_good_frames <= '0;
      stat_bad_frames  <= '0;
      stat_ovf_frames  <= '0;
    end else begin
      tready_q <= 1'b1;
      unique case (state)
        SYNC: begin
          // Skip the tail of any frame that was in flight during reset.
          if (!s_axis.tvalid || s_axis.tlast) state <= WRITE;
        end
        WRITE: begin
          if (beat) begin
            if (full) begin
              wr_ptr <= wr_commit;
              if (s_axis.tlast) stat_ovf_frames <= sat_inc(stat_ovf_frames);
              else              state           <= DROP;
            end else if (!s_axis.tlast) begin
              wr_ptr <= wr_ptr + 1'b1;
            end else if (!s_axis.tuser) begin
              wr_ptr           <= wr_ptr + 1'b1;
              wr_commit        <= wr_ptr + 1'b1;
              stat_good_frames <= sat_inc(stat_good_frames);
            end else begin
              wr_ptr          <= wr_commit;
              stat_bad_frames <= sat_inc(stat_bad_frames);
            end
          end
        end
        DROP: begin
          // tuser is ignored here so an overflowed frame is counted only once.
          if (beat && s_axis.tlast) begin
            stat_ovf_frames <= sat_inc(stat_ovf_frames);
            state           <= WRITE;
          end
        end
        default: state <= SYNC;
      endcase
    end
  end

  // Read request: fetch committed data only when the output and skid registers
  // can absorb the beat that returns one cycle later.
  // NOTE: every output gets a default first so no path leaves a latch behind.
  always_comb begin
    pop   = out_v && m_axis.tready;
    held  = {1'b0, out_v} + {1'b0, skid_v} + {1'b0, rd_pend} - {1'b0, pop};
    rd_en = 1'b0;
    if ((rd_ptr != wr_commit) && (held <= 2'd1)) rd_en = 1'b1;
  end

  // Output register plus skid entry, fed by the registered RAM read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      rd_pend <= 1'b0;
      out_v   <= 1'b0;
      out_q   <= '0;
      skid_v  <= 1'b0;
      skid_q  <= '0;
    end else begin
      rd_pend <= rd_en;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      if (pop || !out_v) begin
        if (skid_v) begin
          out_q  <= skid_q;
          out_v  <= 1'b1;
          skid_v <= rd_pend;
          if (rd_pend) skid_q <= ram_q;
        end else begin
          out_v <= rd_pend;
          if (rd_pend) out_q <= ram_q;
        end
      end else if (rd_pend) begin
        skid_q <= ram_q;
        skid_v <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_eth_rx_frame_fifo.sv
// Self-checking bench: a 2048-deep instance (index 0) and a 16-deep instance
// with 3-bit counters (index 1), each checked against a frame-level model.
module tb_eth_rx_frame_fifo;

  localparam int DW      = 8;
  localparam int DEPTH_B = 2048;
  localparam int DEPTH_S = 16;
  localparam int CW_B    = 32;
  localparam int CW_S    = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  eth_rx_frame_fifo_if #(.DATA_WIDTH(DW)) s_b ();
  eth_rx_frame_fifo_if #(.DATA_WIDTH(DW)) m_b ();
  eth_rx_frame_fifo_if #(.DATA_WIDTH(DW)) s_s ();
  eth_rx_frame_fifo_if #(.DATA_WIDTH(DW)) m_s ();

  logic [CW_B-1:0]          good_b, bad_b, ovf_b;
  logic [CW_S-1:0]          good_s, bad_s, ovf_s;
  logic [$clog2(DEPTH_B):0] lvl_b;
  logic [$clog2(DEPTH_S):0] lvl_s;

  eth_rx_frame_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH_B), .CNT_WIDTH(CW_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .s_axis(s_b), .m_axis(m_b),
    .stat_good_frames(good_b), .stat_bad_frames(bad_b), .stat_ovf_frames(ovf_b),
    .fifo_level(lvl_b)
  );

  eth_rx_frame_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH_S), .CNT_WIDTH(CW_S)) dut_s (
    .clk(clk), .rst_n(rst_n), .s_axis(s_s), .m_axis(m_s),
    .stat_good_frames(good_s), .stat_bad_frames(bad_s), .stat_ovf_frames(ovf_s),
    .fifo_level(lvl_s)
  );

  // Stimulus drivers
  logic [DW-1:0] in_tdata = '0;
  logic          in_tlast = 1'b0;
  logic          in_tuser = 1'b0;
  logic          in_valid [2];
  logic          rdy [2];
  logic          rdy_set [2];
  logic          rand_mode [2];

  assign s_b.tdata  = in_tdata;  assign s_s.tdata  = in_tdata;
  assign s_b.tlast  = in_tlast;  assign s_s.tlast  = in_tlast;
  assign s_b.tuser  = in_tuser;  assign s_s.tuser  = in_tuser;
  assign s_b.tvalid = in_valid[0];
  assign s_s.tvalid = in_valid[1];
  assign m_b.tready = rdy[0];
  assign m_s.tready = rdy[1];

  // Observed outputs, indexed by instance
  logic        obs_v [2];
  logic [8:0]  obs_beat [2];
  logic        obs_sready [2];
  logic [31:0] obs_good [2], obs_bad [2], obs_ovf [2], obs_lvl [2];

  assign obs_v[0] = m_b.tvalid;  assign obs_beat[0] = {m_b.tlast, m_b.tdata};
  assign obs_v[1] = m_s.tvalid;  assign obs_beat[1] = {m_s.tlast, m_s.tdata};
  assign obs_sready[0] = s_b.tready;
  assign obs_sready[1] = s_s.tready;
  assign obs_good[0] = good_b;  assign obs_good[1] = 32'(good_s);
  assign obs_bad[0]  = bad_b;   assign obs_bad[1]  = 32'(bad_s);
  assign obs_ovf[0]  = ovf_b;   assign obs_ovf[1]  = 32'(ovf_s);
  assign obs_lvl[0]  = 32'(lvl_b);
  assign obs_lvl[1]  = 32'(lvl_s);

  // Reference model: expected output beats and statistics per instance
  logic [8:0] q_b [$];
  logic [8:0] q_s [$];
  int exp_good [2], exp_bad [2], exp_ovf [2];
  int committed [2], consumed [2];
  int rise_cyc [2];
  int cyc = 0;
  int last_drive_cyc = 0;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int depth_of(input int d);
    return (d == 0) ? DEPTH_B : DEPTH_S;
  endfunction

  function automatic int sat_inc(input int v, input int d);
    if (d == 1 && v == (1 << CW_S) - 1) return v;
    return v + 1;
  endfunction

  function automatic int exp_size(input int d);
    return (d == 0) ? q_b.size() : q_s.size();
  endfunction

  task automatic exp_push(input int d, input logic [8:0] v);
    if (d == 0) q_b.push_back(v);
    else        q_s.push_back(v);
  endtask

  task automatic exp_pop(input int d, output logic [8:0] v);
    if (d == 0) v = q_b.pop_front();
    else        v = q_s.pop_front();
  endtask

  task automatic clear_model(input int d);
    if (d == 0) q_b.delete();
    else        q_s.delete();
    exp_good[d] = 0; exp_bad[d] = 0; exp_ovf[d] = 0;
    committed[d] = 0; consumed[d] = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid[0] = 1'b0; in_valid[1] = 1'b0;
      in_tlast = 1'b0; in_tuser = 1'b0;
    end
  endtask

  // Drive one frame back-to-back; the model decides its fate from free space.
  task automatic send_frame(input int d, input int len, input bit bad, input bit rnd);
    logic [7:0] data [$];
    int free_est;
    for (int i = 0; i < len; i++) data.push_back(rnd ? 8'($urandom) : 8'(i));
    free_est = depth_of(d) - (committed[d] - consumed[d]);
    if (len > free_est) begin
      exp_ovf[d] = sat_inc(exp_ovf[d], d);
    end else if (bad) begin
      exp_bad[d] = sat_inc(exp_bad[d], d);
    end else begin
      exp_good[d] = sat_inc(exp_good[d], d);
      committed[d] += len;
      for (int i = 0; i < len; i++) exp_push(d, {(i == len - 1), data[i]});
    end
    for (int i = 0; i < len; i++) begin
      @(posedge clk); #1;
      in_tdata = data[i];
      in_tlast = (i == len - 1);
      in_tuser = (i == len - 1) ? bad : 1'($urandom_range(0, 1));
      in_valid[d] = 1'b1;
      in_valid[1 - d] = 1'b0;
    end
    last_drive_cyc = cyc;
  endtask

  task automatic wait_drain(input int d);
    int n = 0;
    while (exp_size(d) != 0 && n < 10000) begin
      @(negedge clk);
      n++;
    end
    check("drain_remaining", 32'(exp_size(d)), 0);
    idle(3);
  endtask

  task automatic check_stats(input int d);
    check("stat_good", obs_good[d], 32'(exp_good[d]));
    check("stat_bad", obs_bad[d], 32'(exp_bad[d]));
    check("stat_ovf", obs_ovf[d], 32'(exp_ovf[d]));
  endtask

  // Cycle counter
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Output-ready driver: fixed level or 50% random per instance
  initial begin
    rdy[0] = 1'b1; rdy[1] = 1'b1;
    forever begin
      @(posedge clk); #2;
      for (int d = 0; d < 2; d++)
        rdy[d] = rand_mode[d] ? 1'($urandom_range(0, 1)) : rdy_set[d];
    end
  end

  // Output monitor: order/content against the model, hold-while-stalled rule
  initial begin
    logic       prev_v [2];
    logic       prev_stall [2];
    logic [8:0] prev_beat [2];
    logic [8:0] e;
    for (int d = 0; d < 2; d++) begin
      prev_v[d] = 1'b0; prev_stall[d] = 1'b0; prev_beat[d] = '0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (!rst_n) begin
          prev_v[d] = 1'b0;
          prev_stall[d] = 1'b0;
          continue;
        end
        if (prev_stall[d]) begin
          check("hold_valid", 32'(obs_v[d]), 1);
          check("hold_beat", 32'(obs_beat[d]), 32'(prev_beat[d]));
        end
        if (obs_v[d] && !prev_v[d] && rise_cyc[d] < 0) rise_cyc[d] = cyc;
        if (obs_v[d] && rdy[d]) begin
          check("beat_expected", 32'(exp_size(d) > 0), 1);
          if (exp_size(d) > 0) begin
            exp_pop(d, e);
            check((d == 0) ? "beat_big" : "beat_small", 32'(obs_beat[d]), 32'(e));
            consumed[d]++;
          end
        end
        prev_v[d]     = obs_v[d];
        prev_stall[d] = obs_v[d] && !rdy[d];
        prev_beat[d]  = obs_beat[d];
      end
    end
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  // Directed sequence
  initial begin
    int tl;
    int len;
    in_valid[0] = 1'b0; in_valid[1] = 1'b0;
    rdy_set[0] = 1'b1; rdy_set[1] = 1'b1;
    rand_mode[0] = 1'b0; rand_mode[1] = 1'b0;
    rise_cyc[0] = -1; rise_cyc[1] = -1;
    clear_model(0);
    clear_model(1);

    // Reset values
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst_s_tready", 32'(obs_sready[d]), 0);
      check("rst_m_tvalid", 32'(obs_v[d]), 0);
      check("rst_m_beat", 32'(obs_beat[d]), 0);
      check("rst_level", obs_lvl[d], 0);
      check_stats(d);
    end
    rst_n = 1'b1;
    idle(4);
    check("s_tready_big", 32'(obs_sready[0]), 1);
    check("s_tready_small", 32'(obs_sready[1]), 1);

    // 64-beat good frame, incrementing data; first beat two edges after commit
    rise_cyc[0] = -1;
    send_frame(0, 64, 1'b0, 1'b0);
    tl = last_drive_cyc;
    idle(1);
    wait_drain(0);
    check("latency_first_beat", 32'(rise_cyc[0]), 32'(tl + 3));
    check_stats(0);
    check("level_after_t1", obs_lvl[0], 0);

    // Bad 60-beat frame followed by a good 10-beat frame
    send_frame(0, 60, 1'b1, 1'b1);
    send_frame(0, 10, 1'b0, 1'b1);
    idle(1);
    wait_drain(0);
    check_stats(0);
    check("level_after_t2", obs_lvl[0], 0);

    // Small buffer, output stalled: 10 commits, then 10 and 16 overflow
    rdy_set[1] = 1'b0;
    idle(3);
    send_frame(1, 10, 1'b0, 1'b1);
    idle(2);
    send_frame(1, 10, 1'b0, 1'b1);
    idle(2);
    send_frame(1, 16, 1'b0, 1'b1);
    idle(4);
    check_stats(1);
    // Two committed beats sit in the output and skid registers
    check("level_stalled", obs_lvl[1], 8);
    rdy_set[1] = 1'b1;
    idle(1);
    wait_drain(1);
    check("level_after_t3", obs_lvl[1], 0);

    // Small buffer boundaries: exactly DEPTH commits, DEPTH+1 overflows,
    // and an overflowing bad frame counts as overflow only
    send_frame(1, 16, 1'b0, 1'b1);
    idle(1);
    wait_drain(1);
    send_frame(1, 17, 1'b0, 1'b1);
    idle(2);
    send_frame(1, 20, 1'b1, 1'b1);
    idle(2);
    check_stats(1);
    check("level_after_t4", obs_lvl[1], 0);

    // Random short frames on the small buffer: pointer wrap and counter saturation
    for (int k = 0; k < 14; k++) begin
      len = $urandom_range(1, 16);
      send_frame(1, len, ($urandom_range(0, 3) == 0), 1'b1);
      idle(1);
      wait_drain(1);
    end
    check_stats(1);
    check("level_after_rand_small", obs_lvl[1], 0);

    // Reset for one cycle at beat 20 of a 40-beat frame
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      in_tdata = 8'($urandom);
      in_tlast = (i == 39);
      in_tuser = 1'b0;
      in_valid[0] = 1'b1;
      rst_n = (i != 20);
      if (i == 20) begin
        clear_model(0);
        clear_model(1);
      end
      if (i == 21) begin
        check("midrst_s_tready", 32'(obs_sready[0]), 0);
        check("midrst_m_tvalid", 32'(obs_v[0]), 0);
        check("midrst_level", obs_lvl[0], 0);
        check_stats(0);
        check_stats(1);
      end
    end
    idle(3);
    send_frame(0, 12, 1'b0, 1'b1);
    idle(1);
    wait_drain(0);
    check_stats(0);
    check("level_after_reset", obs_lvl[0], 0);

    // Preload four frames with output stalled, then drain with no idle cycle
    rdy_set[0] = 1'b0;
    idle(2);
    send_frame(0, 1, 1'b0, 1'b1);
    send_frame(0, 2, 1'b0, 1'b1);
    send_frame(0, 1, 1'b0, 1'b1);
    send_frame(0, 40, 1'b0, 1'b1);
    idle(5);
    check("preload_level", obs_lvl[0], 42);
    rdy_set[0] = 1'b1;
    for (int i = 0; i < 44; i++) begin
      @(negedge clk);
      check("no_idle_valid", 32'(obs_v[0]), 1);
    end
    wait_drain(0);
    check_stats(0);

    // Random output backpressure with back-to-back 1, 2, 1500, 1, 2 beat frames
    rand_mode[0] = 1'b1;
    send_frame(0, 1, 1'b0, 1'b1);
    send_frame(0, 2, 1'b0, 1'b1);
    send_frame(0, 1500, 1'b0, 1'b1);
    send_frame(0, 1, 1'b0, 1'b1);
    send_frame(0, 2, 1'b0, 1'b1);
    idle(1);
    wait_drain(0);
    rand_mode[0] = 1'b0;
    idle(3);
    check_stats(0);
    check("level_final", obs_lvl[0], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
